serial_word_tx: RTL

Parallel-to-serial word transmitter for the datapath's serial operand links. Accepts a W-bit word through a valid/ready handshake and emits it one bit per accepted cycle, LSB first, with first/last framing and a completion pulse. It is the transmit end feeding the serial-load shift registers in the multiplier datapath, which consume exactly W bits LSB first. A downstream stall input provides backpressure.

---
 rtl/serial_word_tx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_word_tx.sv
// serial_word_tx
// Parallel-to-serial word transmitter. A W-bit word is accepted through a
// valid/ready handshake and sent one bit per accepted cycle, LSB first,
// with first/last framing flags and a one-cycle done pulse.
//
// Build option: define SERIAL_TX_PARITY_EN to append an even-parity bit
// after the data bits. That bit then carries ser_last, and the frame is
// W+1 bits long. Without the macro the PARITY state is not built and
// ser_last marks bit W-1.
//
// Every output is decoded from registered state only, so no input
// reaches an output in the same cycle.

module serial_word_tx #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         ser_ready,
  output logic         ser_bit,
  output logic         ser_valid,
  output logic         ser_first,
  output logic         ser_last,
  output logic         busy,
  output logic         done
);

  localparam int                CNT_W    = $clog2(W) + 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_t;

  // Even parity over a data word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [W-1:0] d);
    return ^d;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [W-1:0]     r_shreg;
  logic [CNT_W-1:0] r_cnt;
`ifdef SERIAL_TX_PARITY_EN
  logic             r_par;
`endif

  logic             w_accept;
  logic             w_bit_take;
  logic             w_last_bit;

  // Handshake qualifiers derived from the registered state.
  always_comb begin
    w_accept   = 1'b0;
    w_bit_take = 1'b0;
    w_last_bit = 1'b0;
    if (r_state == S_IDLE) begin
      w_accept = in_valid;
    end else begin
      w_accept = 1'b0;
    end
    if (r_state == S_SHIFT) begin
      w_bit_take = ser_ready;
    end else begin
      w_bit_take = 1'b0;
    end
    w_last_bit = (r_cnt == CNT_LAST);
  end

  // Next-state logic; clr drops any frame in progress and returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_next_state = S_SHIFT;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (ser_ready && w_last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
            w_next_state = S_PARITY;
`else
            w_next_state = S_DONE;
`endif
          end else begin
            w_next_state = S_SHIFT;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (ser_ready) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_PARITY;
          end
        end
`endif
        S_DONE: begin
          w_next_state = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Shift register and bit counter; the counter saturates at W-1 so it
  // never leaves the valid bit range while in SHIFT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_shreg <= '0;
      r_cnt   <= CNT_ZERO;
    end else if (w_accept) begin
      r_shreg <= in_data;
      r_cnt   <= CNT_ZERO;
    end else if (w_bit_take) begin
      r_shreg <= {1'b0, r_shreg[W-1:1]};
      if (w_last_bit) begin
        r_cnt <= r_cnt;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_shreg <= r_shreg;
      r_cnt   <= r_cnt;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity of the word is captured at acceptance, before shifting destroys it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= even_parity(in_data);
    end else begin
      r_par <= r_par;
    end
  end
`endif

  // Output decode from registered state, shift register and counter.
  always_comb begin
    in_ready  = 1'b0;
    ser_bit   = 1'b0;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = r_shreg[0];
        ser_first = (r_cnt == CNT_ZERO);
`ifdef SERIAL_TX_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = w_last_bit;
`endif
        busy      = 1'b1;
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        ser_valid = 1'b1;
        ser_bit   = r_par;
        ser_last  = 1'b1;
        busy      = 1'b1;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
